// File: rtl/playlist_controller.sv
// Playlist sequencer in front of song_reader: turns play/next button pulses and
// song_done into the play level, the song select and a one-cycle reader restart.
module playlist_controller #(
    parameter int NUM_SONGS  = 4,
    parameter int GAP_CYCLES = 16,
    parameter int GAP_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       play_button,
    input  logic       next_button,
    input  logic       repeat_en,
    input  logic       song_done,
    output logic       play,
    output logic [1:0] song,
    output logic       reader_reset,
    output logic [2:0] status
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RESTART = 3'd1;
    localparam logic [2:0] PLAYING = 3'd2;
    localparam logic [2:0] PAUSED  = 3'd3;
    localparam logic [2:0] GAP     = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    localparam logic [1:0]       LAST_SONG = 2'(NUM_SONGS - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [1:0]       song_q, song_d;
    logic             resume_q, resume_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [1:0]       next_song;

    // With a single song this wraps to itself, so song stays 0.
    assign next_song = (song_q == LAST_SONG) ? 2'd0 : song_q + 2'd1;

    always_comb begin
        state_d  = state_q;
        song_d   = song_q;
        resume_d = resume_q;
        gap_d    = gap_q;
        case (state_q)
            IDLE: begin
                if (play_button || next_button) begin
                    state_d  = RESTART;
                    resume_d = 1'b1;
                end
            end
            RESTART: begin
                state_d = resume_q ? PLAYING : PAUSED;
            end
            PLAYING: begin
                if (next_button) begin
                    song_d   = next_song;
                    resume_d = 1'b1;
                    state_d  = RESTART;
                end else if (song_done) begin
                    gap_d   = GAP_LOAD;
                    state_d = GAP;
                end else if (play_button) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                // A skip while paused restarts the reader but stays paused.
                if (next_button) begin
                    song_d   = next_song;
                    resume_d = 1'b0;
                    state_d  = RESTART;
                end else if (play_button) begin
                    state_d = PLAYING;
                end
            end
            GAP: begin
                if (next_button) begin
                    song_d   = next_song;
                    resume_d = 1'b1;
                    state_d  = RESTART;
                end else if (gap_q == '0) begin
                    if (song_q == LAST_SONG && !repeat_en) begin
                        state_d = DONE;
                    end else begin
                        song_d   = next_song;
                        resume_d = 1'b1;
                        state_d  = RESTART;
                    end
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            DONE: begin
                if (play_button || next_button) begin
                    song_d   = 2'd0;
                    resume_d = 1'b1;
                    state_d  = RESTART;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            song_q   <= 2'd0;
            resume_q <= 1'b0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            song_q   <= song_d;
            resume_q <= resume_d;
            gap_q    <= gap_d;
        end
    end

    // Moore outputs; status doubles as the state debug port.
    assign play         = (state_q == PLAYING);
    assign reader_reset = (state_q == RESTART);
    assign status       = state_q;
    assign song         = song_q;

endmodule

// File: tb/tb_playlist_controller.sv
// Directed bench for playlist_controller (NUM_SONGS=4, GAP_CYCLES=4): inputs
// change on the falling edge, outputs are checked on the falling edge.
module tb_playlist_controller;

    logic       clk;
    logic       reset;
    logic       play_button;
    logic       next_button;
    logic       repeat_en;
    logic       song_done;
    logic       play;
    logic [1:0] song;
    logic       reader_reset;
    logic [2:0] status;

    int n_cmp  = 0;
    int n_fail = 0;

    playlist_controller #(.NUM_SONGS(4), .GAP_CYCLES(4), .GAP_W(8)) dut (
        .clk(clk), .reset(reset), .play_button(play_button), .next_button(next_button),
        .repeat_en(repeat_en), .song_done(song_done), .play(play), .song(song),
        .reader_reset(reader_reset), .status(status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic press_play();
        @(negedge clk) play_button = 1'b1;
        @(negedge clk) play_button = 1'b0;
    endtask

    task automatic press_next();
        @(negedge clk) next_button = 1'b1;
        @(negedge clk) next_button = 1'b0;
    endtask

    // Raises song_done for `hold` cycles and counts consecutive GAP cycles.
    task automatic gap_run(input int hold, output int n, output int play_seen);
        @(negedge clk) song_done = 1'b1;
        @(negedge clk);
        n = 0;
        play_seen = 0;
        while (status == 3'd4 && n < 20) begin
            n++;
            if (play !== 1'b0 || reader_reset !== 1'b0) play_seen++;
            if (n >= hold) song_done = 1'b0;
            @(negedge clk);
        end
        song_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (status !== 3'd0) begin n_fail++; $display("FAIL reset_status: got %0d expected 0", status); end
        n_cmp++; if (play !== 1'b0 || reader_reset !== 1'b0 || song !== 2'd0) begin
            n_fail++; $display("FAIL reset_outputs: got play=%0b rr=%0b song=%0d expected 0/0/0", play, reader_reset, song); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (status !== 3'd0) begin n_fail++; $display("FAIL idle_hold: got %0d expected 0", status); end
    endtask

    task automatic test_start();
        press_play();
        n_cmp++; if (status !== 3'd1 || reader_reset !== 1'b1 || play !== 1'b0 || song !== 2'd0) begin
            n_fail++; $display("FAIL start_restart: got st=%0d rr=%0b play=%0b song=%0d expected 1/1/0/0", status, reader_reset, play, song); end
        @(negedge clk);
        n_cmp++; if (status !== 3'd2 || reader_reset !== 1'b0 || play !== 1'b1 || song !== 2'd0) begin
            n_fail++; $display("FAIL start_playing: got st=%0d rr=%0b play=%0b song=%0d expected 2/0/1/0", status, reader_reset, play, song); end
    endtask

    task automatic test_pause_resume();
        press_play();
        n_cmp++; if (status !== 3'd3 || play !== 1'b0 || reader_reset !== 1'b0) begin
            n_fail++; $display("FAIL pause: got st=%0d play=%0b rr=%0b expected 3/0/0", status, play, reader_reset); end
        press_play();
        n_cmp++; if (status !== 3'd2 || play !== 1'b1 || reader_reset !== 1'b0) begin
            n_fail++; $display("FAIL resume: got st=%0d play=%0b rr=%0b expected 2/1/0", status, play, reader_reset); end
    endtask

    task automatic test_auto_advance();
        int n, ps;
        press_next();
        n_cmp++; if (status !== 3'd1 || song !== 2'd1) begin
            n_fail++; $display("FAIL next_restart: got st=%0d song=%0d expected 1/1", status, song); end
        @(negedge clk);
        gap_run(1, n, ps);
        n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL gap_len: got %0d expected 4", n); end
        n_cmp++; if (ps !== 0) begin n_fail++; $display("FAIL gap_silent: got %0d noisy cycles expected 0", ps); end
        n_cmp++; if (status !== 3'd1 || reader_reset !== 1'b1 || song !== 2'd2) begin
            n_fail++; $display("FAIL adv_restart: got st=%0d rr=%0b song=%0d expected 1/1/2", status, reader_reset, song); end
        @(negedge clk);
        n_cmp++; if (status !== 3'd2 || play !== 1'b1 || song !== 2'd2) begin
            n_fail++; $display("FAIL adv_playing: got st=%0d play=%0b song=%0d expected 2/1/2", status, play, song); end
    endtask

    task automatic test_last_song();
        int n, ps;
        repeat_en = 1'b0;
        press_next();
        @(negedge clk);
        n_cmp++; if (status !== 3'd2 || song !== 2'd3) begin
            n_fail++; $display("FAIL to_last: got st=%0d song=%0d expected 2/3", status, song); end
        gap_run(3, n, ps);
        n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL held_done_gap: got %0d expected 4", n); end
        n_cmp++; if (status !== 3'd5 || play !== 1'b0 || song !== 2'd3 || reader_reset !== 1'b0) begin
            n_fail++; $display("FAIL done_state: got st=%0d play=%0b song=%0d rr=%0b expected 5/0/3/0", status, play, song, reader_reset); end
        repeat (2) @(negedge clk);
        n_cmp++; if (status !== 3'd5 || reader_reset !== 1'b0) begin
            n_fail++; $display("FAIL done_hold: got st=%0d rr=%0b expected 5/0", status, reader_reset); end
        press_play();
        n_cmp++; if (status !== 3'd1 || song !== 2'd0) begin
            n_fail++; $display("FAIL done_replay: got st=%0d song=%0d expected 1/0", status, song); end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            press_next();
            @(negedge clk);
        end
        n_cmp++; if (status !== 3'd2 || song !== 2'd3) begin
            n_fail++; $display("FAIL back_to_last: got st=%0d song=%0d expected 2/3", status, song); end
        repeat_en = 1'b1;
        gap_run(1, n, ps);
        n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL repeat_gap: got %0d expected 4", n); end
        n_cmp++; if (status !== 3'd1 || reader_reset !== 1'b1 || song !== 2'd0) begin
            n_fail++; $display("FAIL repeat_wrap: got st=%0d rr=%0b song=%0d expected 1/1/0", status, reader_reset, song); end
        @(negedge clk);
        n_cmp++; if (status !== 3'd2 || play !== 1'b1) begin
            n_fail++; $display("FAIL repeat_play: got st=%0d play=%0b expected 2/1", status, play); end
        repeat_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        next_button = 1'b1; song_done = 1'b1; play_button = 1'b1;
        @(negedge clk);
        next_button = 1'b0; song_done = 1'b0; play_button = 1'b0;
        n_cmp++; if (status !== 3'd1 || song !== 2'd1) begin
            n_fail++; $display("FAIL simul_restart: got st=%0d song=%0d expected 1/1", status, song); end
        @(negedge clk);
        n_cmp++; if (status !== 3'd2 || play !== 1'b1) begin
            n_fail++; $display("FAIL simul_playing: got st=%0d play=%0b expected 2/1", status, play); end
        press_play();
        press_next();
        n_cmp++; if (status !== 3'd1 || reader_reset !== 1'b1 || song !== 2'd2) begin
            n_fail++; $display("FAIL paused_skip: got st=%0d rr=%0b song=%0d expected 1/1/2", status, reader_reset, song); end
        @(negedge clk);
        n_cmp++; if (status !== 3'd3 || play !== 1'b0 || song !== 2'd2) begin
            n_fail++; $display("FAIL paused_stay: got st=%0d play=%0b song=%0d expected 3/0/2", status, play, song); end
        @(negedge clk) song_done = 1'b1;
        @(negedge clk) song_done = 1'b0;
        n_cmp++; if (status !== 3'd3) begin n_fail++; $display("FAIL paused_ignore_done: got %0d expected 3", status); end
        press_play();
        n_cmp++; if (status !== 3'd2 || play !== 1'b1) begin
            n_fail++; $display("FAIL paused_resume: got st=%0d play=%0b expected 2/1", status, play); end
    endtask

    task automatic test_gap_skip();
        press_next();
        @(negedge clk);
        @(negedge clk) song_done = 1'b1;
        @(negedge clk) song_done = 1'b0;
        n_cmp++; if (status !== 3'd4 || song !== 2'd3) begin
            n_fail++; $display("FAIL skip_in_gap: got st=%0d song=%0d expected 4/3", status, song); end
        play_button = 1'b1;
        @(negedge clk) play_button = 1'b0;
        n_cmp++; if (status !== 3'd4) begin n_fail++; $display("FAIL gap_ignore_play: got %0d expected 4", status); end
        next_button = 1'b1;
        @(negedge clk) next_button = 1'b0;
        n_cmp++; if (status !== 3'd1 || reader_reset !== 1'b1 || song !== 2'd0) begin
            n_fail++; $display("FAIL gap_next_wrap: got st=%0d rr=%0b song=%0d expected 1/1/0", status, reader_reset, song); end
        @(negedge clk);
        n_cmp++; if (status !== 3'd2 || song !== 2'd0) begin
            n_fail++; $display("FAIL gap_next_play: got st=%0d song=%0d expected 2/0", status, song); end
    endtask

    task automatic test_async_reset();
        int bad;
        press_next();
        @(negedge clk);
        @(negedge clk) song_done = 1'b1;
        @(negedge clk) song_done = 1'b0;
        @(negedge clk);
        n_cmp++; if (status !== 3'd4 || song !== 2'd1) begin
            n_fail++; $display("FAIL pre_reset_gap: got st=%0d song=%0d expected 4/1", status, song); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (status !== 3'd0 || play !== 1'b0 || song !== 2'd0 || reader_reset !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got st=%0d play=%0b song=%0d rr=%0b expected 0/0/0/0", status, play, song, reader_reset); end
        @(negedge clk) reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (status !== 3'd0 || play !== 1'b0 || song !== 2'd0 || reader_reset !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL post_reset_quiet: got %0d changed cycles expected 0", bad); end
        press_play();
        n_cmp++; if (status !== 3'd1 || reader_reset !== 1'b1 || song !== 2'd0) begin
            n_fail++; $display("FAIL post_reset_start: got st=%0d rr=%0b song=%0d expected 1/1/0", status, reader_reset, song); end
    endtask

    initial begin
        reset = 1'b1;
        play_button = 1'b0;
        next_button = 1'b0;
        repeat_en = 1'b0;
        song_done = 1'b0;
        test_reset();
        test_start();
        test_pause_resume();
        test_auto_advance();
        test_last_song();
        test_back_to_back();
        test_gap_skip();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/playlist_controller.md
Name: playlist_controller

Overview:
- Sequencer in front of song_reader. Turns user button pulses (play/pause, next) into the `play` level, the `song[1:0]` select and a one-cycle restart pulse for song_reader.
- Watches `song_done` and auto-advances through the songs, with a silent gap between songs and an optional repeat-all mode.
- Sits between the debounced button logic and song_reader. song_reader's reset is driven by `reset | reader_reset`.

Parameters:
- NUM_SONGS, 4, number of songs in the ROM; legal range 1..4.
- GAP_CYCLES, 16, silent clock cycles between the end of one song and the start of the next; minimum 1.
- GAP_W, 8, width of the gap counter; must satisfy 2^GAP_W > GAP_CYCLES.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- play_button  input  1  one-cycle pulse; toggles play/pause.
- next_button  input  1  one-cycle pulse; skip to the next song.
- repeat_en  input  1  level; 1 wraps from the last song back to song 0.
- song_done  input  1  from song_reader; may stay high for more than one cycle.
- play  output  1  to song_reader; 1 only in PLAYING.
- song  output  2  song select to song_reader.
- reader_reset  output  1  one-cycle pulse; restarts song_reader at address 0.
- status  output  3  encoded current state, for the LCD/debug.

Behaviour:

Timing conventions
- All state, song, the resume flag and the gap counter are registers on the rising edge of clk.
- Inputs are sampled at edge k. Outputs are Moore, decoded from the registered state, and are valid after edge k.

Reset
- While reset is high: state=IDLE, song=0, resume=0, gap counter=0.
- Outputs during reset: play=0, reader_reset=0, status=0.
- Reset asserted mid-song returns to IDLE immediately; there is no restart pulse.

States and status codes
- IDLE=0, RESTART=1, PLAYING=2, PAUSED=3, GAP=4, DONE=5.

IDLE
- play_button or next_button -> RESTART, resume=1. song is unchanged.

RESTART
- reader_reset=1 for exactly this one cycle; play=0.
- Next state: PLAYING if resume=1, else PAUSED.

PLAYING
- Input priority: next_button > song_done > play_button.
- next_button: song advances, resume=1, -> RESTART.
- song_done: gap counter loads GAP_CYCLES-1, -> GAP.
- play_button: -> PAUSED.

PAUSED
- song_done is ignored.
- next_button (has priority over play_button): song advances, resume=0, -> RESTART. The controller stays paused after the restart.
- play_button: -> PLAYING.

GAP
- play=0; the counter decrements each cycle. play_button is ignored.
- Counter reaches 0 without next_button:
  - If song==NUM_SONGS-1 and repeat_en=0: -> DONE; song keeps its value.
  - Otherwise: song advances, resume=1, -> RESTART.
- next_button: ends the gap immediately; song advances with an unconditional wrap, resume=1, -> RESTART.
- Total silence from the song_done edge to the RESTART cycle is GAP_CYCLES cycles.

DONE
- play=0.
- play_button or next_button: song=0, resume=1, -> RESTART.

Song advance and latency
- Song advance is (song+1) mod NUM_SONGS. With NUM_SONGS=1, song stays 0.
- play_button in IDLE at edge k: reader_reset high after k, play high after k+1.
- PAUSED <-> PLAYING latency is 1 cycle.
- song_done held high for several cycles causes only one GAP entry, because GAP ignores song_done.

Test Plan:
1. Start: reset, then a play_button pulse -> RESTART for 1 cycle with reader_reset=1, then play=1 and song=0 with status=2.
2. Pause/resume mid-song: play_button -> play=0 and status=3 the next cycle, with no reader_reset. A second play_button -> play=1 with no reader_reset.
3. Auto-advance with GAP_CYCLES=4, NUM_SONGS=4:
   - song_done pulses while song=1 -> play=0 for exactly 4 cycles (status=4).
   - Then one reader_reset pulse, song=2, play=1.
4. Last song:
   - song=3, repeat_en=0, song_done -> after the gap, status=5, play=0, song=3, no reader_reset.
   - Repeat with repeat_en=1 -> song=0, reader_reset pulse, then play=1.
5. Simultaneous inputs and skip while paused:
   - In PLAYING, next_button, song_done and play_button in the same cycle -> song advances, RESTART, then PLAYING; GAP is never entered.
   - In PAUSED, next_button -> reader_reset pulse, song+1, status=3, play stays 0.
6. Asynchronous reset mid-GAP, asserted between clock edges -> status=0, play=0, song=0 immediately, before the next edge. After release, no output changes until a button pulse arrives.
